// File: rtl/polinomio_horner_if.sv
// Handshake and data bundle for the Horner polynomial evaluator.
// The master drives the request (inicio, x, coefs); the slave returns the result and status.
interface polinomio_horner_if #(
  parameter int W    = 16,
  parameter int XW   = 8,
  parameter int GRAU = 2
) ();

  logic                    inicio;
  logic [XW-1:0]           x;
  logic [(GRAU+1)*W-1:0]   coefs;
  logic [W-1:0]            resultado;
  logic                    pronto;
  logic                    ocupado;
  logic                    estouro;

  modport master (
    output inicio, x, coefs,
    input  resultado, pronto, ocupado, estouro
  );

  modport slave (
    input  inicio, x, coefs,
    output resultado, pronto, ocupado, estouro
  );

endinterface

// File: rtl/polinomio_horner.sv
// Sequential Horner evaluator: one multiply-accumulate step per cycle, P(x) mod 2^W.
// Optional overflow detection is enabled by defining HORNER_OVERFLOW_FLAG_EN.
module polinomio_horner #(
  parameter int W    = 16,
  parameter int XW   = 8,
  parameter int GRAU = 2
) (
  input logic               clk,
  input logic               rst,
  polinomio_horner_if.slave bus
);

  typedef enum logic [1:0] {OCIOSO, CALC, FIM} estado_t;

  localparam logic [3:0] CNT_INI = (GRAU > 0) ? 4'(GRAU - 1) : 4'd0;

  estado_t                 estado;
  logic [XW-1:0]           x_r;
  logic [(GRAU+1)*W-1:0]   coefs_r;
  logic [W-1:0]            acc;
  logic [3:0]              cnt;
  logic [W-1:0]            resultado_r;
  logic                    pronto_r;
  logic                    ocupado_r;
  logic [W-1:0]            a_cnt;
  logic [W+XW:0]           mac;

  // Full-width step keeps the bits above W so overflow can be observed before truncation.
  assign a_cnt = coefs_r[cnt*W +: W];
  assign mac   = {{(XW+1){1'b0}}, acc} * {{(W+1){1'b0}}, x_r}
               + {{(XW+1){1'b0}}, a_cnt};

`ifdef HORNER_OVERFLOW_FLAG_EN
  logic estouro_r;
  logic passo_estouro;
  assign passo_estouro = |mac[W+XW:W];
  assign bus.estouro   = estouro_r;
`else
  logic unused_mac_hi;
  assign unused_mac_hi = ^mac[W+XW:W];
  assign bus.estouro   = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      estado      <= OCIOSO;
      x_r         <= '0;
      coefs_r     <= '0;
      acc         <= '0;
      cnt         <= '0;
      resultado_r <= '0;
      pronto_r    <= 1'b0;
      ocupado_r   <= 1'b0;
`ifdef HORNER_OVERFLOW_FLAG_EN
      estouro_r   <= 1'b0;
`endif
    end else begin
      case (estado)
        OCIOSO: begin
          pronto_r <= 1'b0;
          if (bus.inicio) begin
            x_r       <= bus.x;
            coefs_r   <= bus.coefs;
            acc       <= bus.coefs[GRAU*W +: W];
            cnt       <= CNT_INI;
            ocupado_r <= 1'b1;
`ifdef HORNER_OVERFLOW_FLAG_EN
            estouro_r <= 1'b0;
`endif
            // A constant polynomial has no steps to run, so it completes immediately.
            if (GRAU == 0) begin
              estado      <= FIM;
              resultado_r <= bus.coefs[W-1:0];
              pronto_r    <= 1'b1;
            end else begin
              estado <= CALC;
            end
          end
        end
        CALC: begin
          acc <= mac[W-1:0];
`ifdef HORNER_OVERFLOW_FLAG_EN
          estouro_r <= estouro_r | passo_estouro;
`endif
          if (cnt == 4'd0) begin
            estado      <= FIM;
            resultado_r <= mac[W-1:0];
            pronto_r    <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        FIM: begin
          pronto_r  <= 1'b0;
          ocupado_r <= 1'b0;
          estado    <= OCIOSO;
        end
        default: begin
          pronto_r  <= 1'b0;
          ocupado_r <= 1'b0;
          estado    <= OCIOSO;
        end
      endcase
    end
  end

  assign bus.resultado = resultado_r;
  assign bus.pronto    = pronto_r;
  assign bus.ocupado   = ocupado_r;

endmodule

// File: tb/tb_polinomio_horner.sv
// Scoreboard bench for polinomio_horner: default (GRAU=2), constant (GRAU=0) and wide (GRAU=4, W=32) builds.
module tb_polinomio_horner;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  polinomio_horner_if #(.W(16), .XW(8), .GRAU(2)) bus ();
  polinomio_horner_if #(.W(16), .XW(8), .GRAU(0)) bus0 ();
  polinomio_horner_if #(.W(32), .XW(8), .GRAU(4)) bus4 ();

  polinomio_horner #(.W(16), .XW(8), .GRAU(2)) dut (.clk(clk), .rst(rst), .bus(bus));
  polinomio_horner #(.W(16), .XW(8), .GRAU(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  polinomio_horner #(.W(32), .XW(8), .GRAU(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference value from the power-series form, independent of the step-by-step recurrence.
  function automatic logic [15:0] evalPoly(input logic [15:0] a2, input logic [15:0] a1,
                                           input logic [15:0] a0, input logic [7:0] xv);
    logic [63:0] s;
    s = 64'(a0) + 64'(a1) * 64'(xv) + 64'(a2) * 64'(xv) * 64'(xv);
    return s[15:0];
  endfunction

  function automatic logic evalOvf(input logic [15:0] a2, input logic [15:0] a1,
                                   input logic [15:0] a0, input logic [7:0] xv);
`ifdef HORNER_OVERFLOW_FLAG_EN
    logic [63:0] f1;
    logic [63:0] f2;
    f1 = 64'(a2) * 64'(xv) + 64'(a1);
    f2 = 64'(f1[15:0]) * 64'(xv) + 64'(a0);
    return (f1[63:16] != 0) || (f2[63:16] != 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic exp_t mkExp(input logic [15:0] a2, input logic [15:0] a1,
                                 input logic [15:0] a0, input logic [7:0] xv, input int c);
    exp_t e;
    e.res = evalPoly(a2, a1, a0, xv);
    e.ovf = evalOvf(a2, a1, a0, xv);
    e.cyc = c;
    return e;
  endfunction

  // Monitor: every pronto pulse of the default instance must match the oldest expectation.
  always @(negedge clk) begin
    if (bus.pronto === 1'b1) begin
      if (sb.size() == 0) begin
        checkOutput("unexpected_pronto", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("resultado", 64'(bus.resultado), 64'(e.res));
        checkOutput("estouro", 64'(bus.estouro), 64'(e.ovf));
        checkOutput("latency", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] a2, input logic [15:0] a1,
                               input logic [15:0] a0, input logic [7:0] xv);
    @(posedge clk);
    #1;
    bus.coefs  = {a2, a1, a0};
    bus.x      = xv;
    bus.inicio = 1'b1;
    sb.push_back(mkExp(a2, a1, a0, xv, cyc + 3));
    @(posedge clk);
    #1;
    bus.inicio = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checkOutput("timeout_pending", 64'(sb.size()), 64'd0);
      sb.delete();
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int c;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.inicio  = 1'b0; bus.x  = '0; bus.coefs  = '0;
    bus0.inicio = 1'b0; bus0.x = '0; bus0.coefs = '0;
    bus4.inicio = 1'b0; bus4.x = '0; bus4.coefs = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_resultado", 64'(bus.resultado), 64'd0);
    checkOutput("rst_pronto", 64'(bus.pronto), 64'd0);
    checkOutput("rst_ocupado", 64'(bus.ocupado), 64'd0);
    checkOutput("rst_estouro", 64'(bus.estouro), 64'd0);

    // Basic example: 5x^2+3x+4 at x=2.
    applyStimulus(16'd5, 16'd3, 16'd4, 8'd2);
    @(negedge clk);
    checkOutput("ocupado_calc", 64'(bus.ocupado), 64'd1);
    checkOutput("pronto_early", 64'(bus.pronto), 64'd0);
    waitIdle(20);
    checkOutput("ocupado_idle", 64'(bus.ocupado), 64'd0);
    checkOutput("resultado_hold", 64'(bus.resultado), 64'd30);

    // All-ones coefficients with maximal x: wraps to 0x00FF.
    applyStimulus(16'hFFFF, 16'hFFFF, 16'hFFFF, 8'd255);
    waitIdle(20);

    // inicio held high; x changes after capture and only affects later operations.
    @(posedge clk);
    #1;
    bus.coefs  = {16'd5, 16'd3, 16'd4};
    bus.x      = 8'd2;
    bus.inicio = 1'b1;
    c = cyc;
    sb.push_back(mkExp(16'd5, 16'd3, 16'd4, 8'd2, c + 3));
    sb.push_back(mkExp(16'd5, 16'd3, 16'd4, 8'd7, c + 7));
    sb.push_back(mkExp(16'd5, 16'd3, 16'd4, 8'd7, c + 11));
    @(posedge clk);
    #1;
    bus.x = 8'd7;
    repeat (8) @(posedge clk);
    #1;
    bus.inicio = 1'b0;
    waitIdle(30);

    for (int i = 0; i < 4; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
      waitIdle(20);
    end

    // Reset wins over a simultaneous start request.
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.inicio = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.inicio = 1'b0;
    @(negedge clk);
    checkOutput("rst_prio_ocupado", 64'(bus.ocupado), 64'd0);

    // Abort on the first CALC edge, then recover with a fresh operation.
    @(posedge clk);
    #1;
    bus.coefs  = {16'd5, 16'd3, 16'd4};
    bus.x      = 8'd2;
    bus.inicio = 1'b1;
    @(posedge clk);
    #1;
    bus.inicio = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("abort_resultado", 64'(bus.resultado), 64'd0);
    checkOutput("abort_pronto", 64'(bus.pronto), 64'd0);
    checkOutput("abort_ocupado", 64'(bus.ocupado), 64'd0);
    checkOutput("abort_estouro", 64'(bus.estouro), 64'd0);
    repeat (5) @(posedge clk);
    applyStimulus(16'd5, 16'd3, 16'd4, 8'd2);
    waitIdle(20);

    // Constant polynomial and degree-4 wide instance started on the same edge.
    @(posedge clk);
    #1;
    bus0.coefs  = 16'h1234;
    bus0.x      = 8'd9;
    bus0.inicio = 1'b1;
    bus4.coefs  = {32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    bus4.x      = 8'd3;
    bus4.inicio = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      bus0.inicio = 1'b0;
      bus4.inicio = 1'b0;
      checkOutput($sformatf("g0_pronto_%0d", k), 64'(bus0.pronto), 64'(k == 1));
      checkOutput($sformatf("g4_pronto_%0d", k), 64'(bus4.pronto), 64'(k == 5));
      if (k == 1) checkOutput("g0_resultado", 64'(bus0.resultado), 64'h1234);
      if (k == 3) checkOutput("g4_ocupado", 64'(bus4.ocupado), 64'd1);
      if (k == 5) checkOutput("g4_resultado", 64'(bus4.resultado), 64'd179);
    end

    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
